// File: rtl/line_sensor_adc_scan.sv
// ============================================================================
// Module   : line_sensor_adc_scan
// Brief    : SPI scan engine for an ADC128S022. Cycles through three channels,
//            keeps the newest 12-bit result per channel, pulses scan_done when
//            the third slot is refreshed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_sensor_adc_scan #(
  parameter int         CLK_DIV = 2,
  parameter int         GAP     = 2,
  parameter logic [2:0] CH0     = 3'd0,
  parameter logic [2:0] CH1     = 3'd1,
  parameter logic [2:0] CH2     = 3'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] out0,
  output logic [11:0] out1,
  output logic [11:0] out2,
  output logic        scan_done
);

  localparam int c_ph_w  = $clog2(2 * CLK_DIV);
  localparam int c_gap_w = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(2 * CLK_DIV - 1);
  localparam logic [c_ph_w-1:0]  c_ph_rise  = c_ph_w'(CLK_DIV);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_ph_w-1:0]   r_ph;
  logic [3:0]          r_bit;
  logic [c_gap_w-1:0]  r_gap;
  logic [1:0]          r_slot;
  logic [1:0]          r_prev_slot;
  logic                r_prime;
  logic [15:0]         r_shift;
  logic [15:0]         w_shift_next;
  logic [11:0]         r_out0;
  logic [11:0]         r_out1;
  logic [11:0]         r_out2;
  logic                r_scan_done;
  logic [2:0]          w_addr;
  logic [15:0]         w_word;
  logic                w_in_frame;
  logic                w_frame_last;
  logic                w_gap_last;
  logic                w_sample;

  assign w_in_frame   = (r_state == S_FRAME);
  assign w_frame_last = w_in_frame && (r_bit == 4'd15) && (r_ph == c_ph_last);
  assign w_gap_last   = (r_state == S_GAP) && (r_gap == c_gap_last);
  // dout is taken in the first high cycle of each SCLK period
  assign w_sample     = w_in_frame && (r_ph == c_ph_rise);
  assign w_word       = {2'b00, w_addr, 11'd0};
  assign w_shift_next = w_sample ? ((r_shift << 1) | {15'd0, adc_dout}) : r_shift;

  // Map the scan slot to the configured ADC channel
  always_comb begin
    w_addr = CH2;
    case (r_slot)
      2'd0:    w_addr = CH0;
      2'd1:    w_addr = CH1;
      default: w_addr = CH2;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and SPI pin decode; din follows the bit index, which only moves on SCLK fall
  always_comb begin
    w_state_next = r_state;
    adc_cs_n     = 1'b1;
    adc_sclk     = 1'b1;
    adc_din      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_next = S_FRAME;
      end
      S_FRAME: begin
        adc_cs_n = 1'b0;
        adc_sclk = (r_ph >= c_ph_rise);
        adc_din  = w_word[4'd15 - r_bit];
        if (w_frame_last) w_state_next = S_GAP;
      end
      S_GAP: begin
        if (w_gap_last) w_state_next = en ? S_FRAME : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bit/phase counters inside a frame and the inter-frame gap counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph  <= '0;
      r_bit <= 4'd0;
      r_gap <= '0;
    end else begin
      r_ph  <= '0;
      r_gap <= '0;
      if (w_in_frame) begin
        r_bit <= r_bit;
        if (r_ph == c_ph_last) r_bit <= r_bit + 4'd1;
        else                   r_ph  <= r_ph + 1'b1;
      end else begin
        r_bit <= 4'd0;
      end
      if ((r_state == S_GAP) && !w_gap_last) r_gap <= r_gap + 1'b1;
    end
  end

  // Shift in dout, commit the previous frame's result at frame end, advance the pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot      <= 2'd0;
      r_prev_slot <= 2'd0;
      r_prime     <= 1'b1;
      r_shift     <= 16'd0;
      r_out0      <= 12'd0;
      r_out1      <= 12'd0;
      r_out2      <= 12'd0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      r_shift     <= w_shift_next;
      if (w_frame_last) begin
        // Data arriving now belongs to the address sent in the previous frame
        if (!r_prime) begin
          case (r_prev_slot)
            2'd0: r_out0 <= w_shift_next[11:0];
            2'd1: r_out1 <= w_shift_next[11:0];
            2'd2: begin
              r_out2      <= w_shift_next[11:0];
              r_scan_done <= 1'b1;
            end
            default: begin end
          endcase
        end
        r_prime     <= 1'b0;
        r_prev_slot <= r_slot;
        r_slot      <= (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
      end
      // Dropping to idle restarts the sequence at CH0 with a fresh prime frame
      if (w_gap_last && !en) begin
        r_slot  <= 2'd0;
        r_prime <= 1'b1;
      end
    end
  end

  assign out0      = r_out0;
  assign out1      = r_out1;
  assign out2      = r_out2;
  assign scan_done = r_scan_done;

endmodule

`default_nettype wire
